nabp_filter_line_feeder: RTL and testbench

//  Producer end of the filtered-RAM fill interface: for each scheduled projection line, pulses hs_fill_kick and,
//  in lockstep with the RAM block's read counter (hs_s_val), fetches raw sinogram samples and drives the
//  FIR-filtered value hs_val for the RAM's write pointer. Sits between the line scheduler and the swappable

---
 rtl/nabp_filter_pkg.sv | 23 ++
 rtl/nabp_fir_mac.sv | 60 ++++++
 rtl/nabp_filter_line_feeder.sv | 94 +++++++++
 tb/tb_nabp_filter_line_feeder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_filter_pkg.sv
// Shared constants for the filtered-RAM line feeder: default FIR kernel,
// fixed-point scaling and the feeder FSM state encoding.
package nabp_filter_pkg;

   localparam int ORDER_DEF   = 4;
   localparam int COEFF_W_DEF = 16;
   localparam int kFracBits   = 8;

   // Default symmetric smoothing kernel in Q8 (unity DC gain: 16+32+160+32+16 = 256).
   localparam logic signed [COEFF_W_DEF-1:0] kFilterCoeffs [0:ORDER_DEF] =
      '{16'sd16, 16'sd32, 16'sd160, 16'sd32, 16'sd16};

   // Packed form of the kernel: coefficient j lives at bits [j*COEFF_W +: COEFF_W].
   localparam logic [(ORDER_DEF+1)*COEFF_W_DEF-1:0] kFilterCoeffVec =
      {kFilterCoeffs[4], kFilterCoeffs[3], kFilterCoeffs[2], kFilterCoeffs[1], kFilterCoeffs[0]};

   // Feeder FSM encoding.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_KICK = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/nabp_fir_mac.sv
// Combinational FIR multiply-accumulate over ORDER+1 taps, followed by an
// arithmetic (floor) shift by FRAC_BITS and saturation to FDATA_W signed.
module nabp_fir_mac
   import nabp_filter_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int FDATA_W   = 16,
   parameter int ORDER     = ORDER_DEF,
   parameter int COEFF_W   = COEFF_W_DEF,
   parameter int FRAC_BITS = kFracBits,
   parameter logic [(ORDER+1)*COEFF_W-1:0] COEFFS = kFilterCoeffVec
) (
   input  logic [DATA_W-1:0]         x_cur,
   input  logic [ORDER*DATA_W-1:0]   taps,
   output logic signed [FDATA_W-1:0] y
);

   // Wide enough that ORDER+1 unsigned-sample by signed-coefficient products never overflow.
   localparam int ACC_W = DATA_W + COEFF_W + $clog2(ORDER+1) + 1;

   // Arithmetic right shift: truncation toward minus infinity.
   function automatic logic signed [ACC_W-1:0] shift_floor(input logic signed [ACC_W-1:0] v);
      return v >>> FRAC_BITS;
   endfunction

   // Clamp to the signed FDATA_W range; in range when all bits above the result sign agree.
   function automatic logic signed [FDATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-FDATA_W:0] hi;
      hi = v[ACC_W-1:FDATA_W-1];
      if (hi == '0 || hi == '1)
         return v[FDATA_W-1:0];
      else if (v[ACC_W-1])
         return {1'b1, {(FDATA_W-1){1'b0}}};
      else
         return {1'b0, {(FDATA_W-1){1'b1}}};
   endfunction

   logic [(ORDER+1)*DATA_W-1:0] win;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     samp;
   logic signed [ACC_W-1:0]     coef;

   // Window element j: j=0 is the current sample, j>=1 is tap j-1.
   assign win = {taps, x_cur};

   // Sum of coefficient-weighted window samples, samples zero-extended to signed.
   always_comb begin
      acc  = '0;
      samp = '0;
      coef = '0;
      for (int j = 0; j <= ORDER; j++) begin
         samp = ACC_W'($signed({1'b0, win[j*DATA_W +: DATA_W]}));
         coef = ACC_W'($signed(COEFFS[j*COEFF_W +: COEFF_W]));
         acc  = acc + samp * coef;
      end
   end

   assign y = saturate(shift_floor(acc));

endmodule

// File: rtl/nabp_filter_line_feeder.sv
// Producer side of the filtered-RAM fill: kicks the RAM for each scheduled
// line, follows its read counter to fetch raw samples and drives the
// FIR-filtered value for the RAM's write pointer with zero latency.
module nabp_filter_line_feeder
   import nabp_filter_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int FDATA_W   = 16,
   parameter int S_W       = 9,
   parameter int LINE_SIZE = 256,
   parameter int ORDER     = ORDER_DEF,
   parameter int COEFF_W   = COEFF_W_DEF,
   parameter int FRAC_BITS = kFracBits,
   parameter int ANGLE_W   = 8,
   parameter logic [(ORDER+1)*COEFF_W-1:0] COEFFS = kFilterCoeffVec
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      line_kick,
   input  logic [ANGLE_W-1:0]        line_angle,
   output logic                      line_ready,
   output logic                      line_done,
   output logic [ANGLE_W-1:0]        sg_angle,
   output logic [S_W-1:0]            sg_s_val,
   input  logic [DATA_W-1:0]         sg_val,
   output logic                      hs_fill_kick,
   input  logic                      hs_fill_done,
   input  logic [S_W-1:0]            hs_s_val,
   output logic signed [FDATA_W-1:0] hs_val
);

   // One extra bit so LINE_SIZE == 2**S_W still compares correctly.
   localparam logic [S_W:0] LINE_END = (S_W+1)'(LINE_SIZE);

   logic [1:0]              state;
   logic [ANGLE_W-1:0]      angle_q;
   logic [ORDER*DATA_W-1:0] taps;
   logic [DATA_W-1:0]       x_cur;

   // Line sequencing and angle latch; line_kick only counts in IDLE, fill-done only in BUSY.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         angle_q <= '0;
      end else begin
         case (state)
            ST_IDLE: if (line_kick) begin
               angle_q <= line_angle;
               state   <= ST_KICK;
            end
            ST_KICK: state <= ST_BUSY;
            ST_BUSY: if (hs_fill_done) state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Tap delay line: shifts every BUSY cycle, held clear otherwise so each line starts zero-padded.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         taps <= '0;
      else if (state == ST_BUSY)
         taps <= {taps[(ORDER-1)*DATA_W-1:0], x_cur};
      else
         taps <= '0;
   end

   // Current sample, zero past the end of the line (RAM parks its read index at LINE_SIZE) and outside BUSY.
   always_comb begin
      x_cur = '0;
      if (state == ST_BUSY && {1'b0, hs_s_val} < LINE_END)
         x_cur = sg_val;
   end

   assign line_ready   = (state == ST_IDLE);
   assign line_done    = (state == ST_DONE);
   assign hs_fill_kick = (state == ST_KICK);
   assign sg_angle     = angle_q;
   assign sg_s_val     = hs_s_val;

   nabp_fir_mac #(
      .DATA_W    (DATA_W),
      .FDATA_W   (FDATA_W),
      .ORDER     (ORDER),
      .COEFF_W   (COEFF_W),
      .FRAC_BITS (FRAC_BITS),
      .COEFFS    (COEFFS)
   ) u_mac (
      .x_cur (x_cur),
      .taps  (taps),
      .y     (hs_val)
   );

endmodule

// File: tb/tb_nabp_filter_line_feeder.sv
// Bench for nabp_filter_line_feeder: two feeders (positive kernel, and a mixed-sign
// kernel with fractional bits) share one behavioural filtered-RAM model.
module tb_nabp_filter_line_feeder;

   localparam int DATA_W = 8, FDATA_W = 8, S_W = 5, LINE_SIZE = 16;
   localparam int ORDER = 4, COEFF_W = 16, ANGLE_W = 8, HALF = ORDER / 2;
   localparam logic [79:0] C1_VEC = {16'sd1, 16'sd2, 16'sd4, 16'sd2, 16'sd1};
   localparam logic [79:0] C2_VEC = {-16'sd5, 16'sd3, -16'sd1, 16'sd3, -16'sd5};
   localparam int C1 [0:4] = '{1, 2, 4, 2, 1};
   localparam int C2 [0:4] = '{-5, 3, -1, 3, -5};

   logic clk = 1'b0;
   logic reset_n;
   logic line_kick;
   logic [ANGLE_W-1:0] line_angle;
   logic hs_fill_done;
   logic [S_W-1:0] hs_s_val;

   logic line_ready1, line_done1, kick1;
   logic [ANGLE_W-1:0] sg_angle1;
   logic [S_W-1:0] sg_s_val1;
   logic [DATA_W-1:0] sg_val1;
   logic signed [FDATA_W-1:0] hs_val1;

   logic line_ready2, line_done2, kick2;
   logic [ANGLE_W-1:0] sg_angle2;
   logic [S_W-1:0] sg_s_val2;
   logic [DATA_W-1:0] sg_val2;
   logic signed [FDATA_W-1:0] hs_val2;

   always #5 clk = ~clk;

   nabp_filter_line_feeder #(
      .DATA_W(DATA_W), .FDATA_W(FDATA_W), .S_W(S_W), .LINE_SIZE(LINE_SIZE), .ORDER(ORDER),
      .COEFF_W(COEFF_W), .FRAC_BITS(0), .ANGLE_W(ANGLE_W), .COEFFS(C1_VEC)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .line_kick(line_kick), .line_angle(line_angle),
      .line_ready(line_ready1), .line_done(line_done1), .sg_angle(sg_angle1), .sg_s_val(sg_s_val1),
      .sg_val(sg_val1), .hs_fill_kick(kick1), .hs_fill_done(hs_fill_done), .hs_s_val(hs_s_val),
      .hs_val(hs_val1)
   );

   nabp_filter_line_feeder #(
      .DATA_W(DATA_W), .FDATA_W(FDATA_W), .S_W(S_W), .LINE_SIZE(LINE_SIZE), .ORDER(ORDER),
      .COEFF_W(COEFF_W), .FRAC_BITS(2), .ANGLE_W(ANGLE_W), .COEFFS(C2_VEC)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .line_kick(line_kick), .line_angle(line_angle),
      .line_ready(line_ready2), .line_done(line_done2), .sg_angle(sg_angle2), .sg_s_val(sg_s_val2),
      .sg_val(sg_val2), .hs_fill_kick(kick2), .hs_fill_done(hs_fill_done), .hs_s_val(hs_s_val),
      .hs_val(hs_val2)
   );

   // Sinogram buffer; reads past the line end return junk that the feeder must gate off.
   logic [7:0] sino [0:255][0:15];
   int xline [0:15];

   always_comb begin
      sg_val1 = 8'hA5;
      if (sg_s_val1 < 5'd16) sg_val1 = sino[sg_angle1][sg_s_val1[3:0]];
   end
   always_comb begin
      sg_val2 = 8'hA5;
      if (sg_s_val2 < 5'd16) sg_val2 = sino[sg_angle2][sg_s_val2[3:0]];
   end

   // Filtered RAM model: read index leads write index by HALF, saturates at LINE_SIZE.
   int ram_cnt;
   logic ram_busy;
   logic signed [7:0] ram1 [0:15];
   logic signed [7:0] ram2 [0:15];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ram_busy <= 1'b0; ram_cnt <= 0; hs_s_val <= '0; hs_fill_done <= 1'b0;
      end else if (!ram_busy) begin
         if (kick1) begin
            ram_busy <= 1'b1; ram_cnt <= 0; hs_s_val <= '0; hs_fill_done <= 1'b0;
         end
      end else begin
         if (ram_cnt >= HALF) begin
            ram1[ram_cnt-HALF] <= hs_val1;
            ram2[ram_cnt-HALF] <= hs_val2;
         end
         if (ram_cnt == LINE_SIZE + HALF - 1) begin
            ram_busy <= 1'b0; hs_fill_done <= 1'b0;
         end else begin
            ram_cnt      <= ram_cnt + 1;
            hs_s_val     <= S_W'((ram_cnt + 1 > LINE_SIZE) ? LINE_SIZE : ram_cnt + 1);
            hs_fill_done <= (ram_cnt + 1 == LINE_SIZE + HALF - 1);
         end
      end
   end

   // Event monitors for pulse counting and timing.
   int cyc = 0, kicks = 0, dones = 0, ld_cyc = 0, fd_cyc = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (kick1) kicks <= kicks + 1;
      if (line_done1) begin dones <= dones + 1; ld_cyc <= cyc; end
      if (hs_fill_done && ram_busy) fd_cyc <= cyc;
   end

   int total = 0, bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: y[k] = floor(sum_j c[j]*x[k+HALF-j] / 2^frac), zero outside the line, saturated to 8 bits.
   function automatic int model_y(input int k, input int which);
      int acc, idx;
      acc = 0;
      for (int j = 0; j <= ORDER; j++) begin
         idx = k + HALF - j;
         if (idx >= 0 && idx < LINE_SIZE) acc += ((which == 0) ? C1[j] : C2[j]) * xline[idx];
      end
      if (which != 0) acc = acc >>> 2;
      if (acc > 127) acc = 127;
      if (acc < -128) acc = -128;
      return acc;
   endfunction

   // mode 0: impulse val at pos; mode 1: constant val; mode 2: random.
   task automatic load_line(input int ang, input int mode, input int val, input int pos);
      int v;
      for (int i = 0; i < LINE_SIZE; i++) begin
         v = (mode == 0) ? ((i == pos) ? val : 0) : (mode == 1) ? val : int'($urandom_range(0, 255));
         sino[ang][i] = 8'(v);
         xline[i] = v;
      end
   endtask

   task automatic kick_line(input int ang);
      int n;
      n = 0;
      while (!line_ready1 && n < 200) begin @(negedge clk); n++; end
      if (!line_ready1) chk("ready_timeout", 0, 1);
      line_kick = 1'b1; line_angle = 8'(ang);
      @(negedge clk);
      line_kick = 1'b0;
   endtask

   task automatic wait_done();
      int n, d0;
      n = 0; d0 = dones;
      while (dones == d0 && n < 100) begin @(negedge clk); n++; end
      chk("line_done_seen", int'(dones != d0), 1);
   endtask

   task automatic check_line(input string tag);
      for (int k = 0; k < LINE_SIZE; k++) begin
         chk($sformatf("%s_y1[%0d]", tag, k), int'(ram1[k]), model_y(k, 0));
         chk($sformatf("%s_y2[%0d]", tag, k), int'(ram2[k]), model_y(k, 1));
      end
   endtask

   typedef struct {
      string name;
      int    mode;
      int    val;
      int    pos;
      int    exp1 [0:15];
      int    exp2 [0:15];
   } vec_t;

   vec_t tbl [0:2];

   initial begin
      int k0, d0, n;

      tbl[0].name = "impulse"; tbl[0].mode = 0; tbl[0].val = 10; tbl[0].pos = 5;
      tbl[0].exp1 = '{0,0,0,10,20,40,20,10,0,0,0,0,0,0,0,0};
      tbl[0].exp2 = '{0,0,0,-13,7,-3,7,-13,0,0,0,0,0,0,0,0};
      tbl[1].name = "edges"; tbl[1].mode = 1; tbl[1].val = 1; tbl[1].pos = 0;
      tbl[1].exp1 = '{7,9,10,10,10,10,10,10,10,10,10,10,10,10,9,7};
      tbl[1].exp2 = '{-1,0,-2,-2,-2,-2,-2,-2,-2,-2,-2,-2,-2,-2,0,-1};
      tbl[2].name = "saturate"; tbl[2].mode = 1; tbl[2].val = 255; tbl[2].pos = 0;
      tbl[2].exp1 = '{127,127,127,127,127,127,127,127,127,127,127,127,127,127,127,127};
      tbl[2].exp2 = '{-128,0,-128,-128,-128,-128,-128,-128,-128,-128,-128,-128,-128,-128,0,-128};

      for (int a = 0; a < 256; a++)
         for (int i = 0; i < 16; i++) sino[a][i] = 8'h00;

      reset_n = 1'b0; line_kick = 1'b0; line_angle = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(line_ready1), 1);
      chk("rst_done", int'(line_done1), 0);
      chk("rst_kick", int'(kick1), 0);
      chk("rst_angle", int'(sg_angle1), 0);
      chk("rst_hs_val", int'(hs_val1), 0);
      chk("rst_ready2", int'(line_ready2), 1);
      chk("rst_done2", int'(line_done2), 0);
      chk("rst_kick2", int'(kick2), 0);
      chk("rst_angle2", int'(sg_angle2), 0);
      chk("rst_hs_val2", int'(hs_val2), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table-driven fixed patterns, each on its own angle row.
      for (int r = 0; r < 3; r++) begin
         load_line(r + 1, tbl[r].mode, tbl[r].val, tbl[r].pos);
         kick_line(r + 1);
         wait_done();
         for (int k = 0; k < LINE_SIZE; k++) begin
            chk($sformatf("%s_y1[%0d]", tbl[r].name, k), int'(ram1[k]), tbl[r].exp1[k]);
            chk($sformatf("%s_y2[%0d]", tbl[r].name, k), int'(ram2[k]), tbl[r].exp2[k]);
         end
      end

      // Handshake: a second kick during BUSY is ignored.
      load_line(3, 2, 0, 0);
      k0 = kicks; d0 = dones;
      kick_line(3);
      repeat (5) @(negedge clk);
      chk("busy_ready_low", int'(line_ready1), 0);
      chk("busy_angle", int'(sg_angle1), 3);
      line_kick = 1'b1; line_angle = 8'd7;
      @(negedge clk);
      line_kick = 1'b0;
      wait_done();
      chk("idle_ready_high", int'(line_ready1), 1);
      chk("done_pulse_low", int'(line_done1), 0);
      chk("done_after_fill", ld_cyc - fd_cyc, 1);
      repeat (3) @(negedge clk);
      chk("single_kick", kicks - k0, 1);
      chk("single_done", dones - d0, 1);
      chk("angle_held", int'(sg_angle1), 3);
      check_line("hs");

      // Reset while the RAM is at fill index 6.
      load_line(5, 2, 0, 0);
      kick_line(5);
      n = 0;
      while (ram_cnt != HALF + 6 && n < 50) begin @(negedge clk); n++; end
      chk("reach_idx6", ram_cnt, HALF + 6);
      d0 = dones;
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", int'(line_ready1), 1);
      chk("mid_rst_hs_val", int'(hs_val1), 0);
      reset_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_rst_no_done", dones - d0, 0);
      chk("mid_rst_idle", int'(line_ready1), 1);
      chk("mid_rst_taps_zero", int'(hs_val1), 0);
      load_line(6, 2, 0, 0);
      kick_line(6);
      wait_done();
      check_line("post_rst");

      // Back-to-back random lines, kicked as soon as the feeder is ready.
      for (int l = 0; l < 5; l++) begin
         load_line(10 + l, 2, 0, 0);
         kick_line(10 + l);
         wait_done();
         check_line($sformatf("b2b%0d", l));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
